caravel_bus_arbiter: RTL and testbench
======================================

CARAVEL_BUS_ARBITER -- requirements
Module: caravel_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd255, bus-timeout threshold in cycles; 0 disables the timeout.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset; asynchronous, active-high.
REQ-004 masterN_wb_cyc_i, masterN_wb_stb_i, masterN_wb_we_i  input  1 each  requester N (N = 0, 1) cycle, strobe and write enable.
REQ-005 masterN_wb_sel_i  input  4  requester N byte select.
REQ-006 masterN_wb_data_i  input  32  requester N write data.
REQ-007 masterN_wb_adr_i  input  28  requester N address.
REQ-008 masterN_wb_ack_o, masterN_wb_stall_o, masterN_wb_error_o  output  1 each  responses to requester N.
REQ-009 masterN_wb_data_o  output  32  read data to requester N.
REQ-010 caravel_wb_cyc_o, caravel_wb_stb_o, caravel_wb_we_o  output  1 each  shared Caravel wishbone master port.
REQ-011 caravel_wb_sel_o  output  4  shared port byte select.
REQ-012 caravel_wb_data_o  output  32  shared port write data.
REQ-013 caravel_wb_adr_o  output  28  shared port address.
REQ-014 caravel_wb_ack_i, caravel_wb_stall_i, caravel_wb_error_i  input  1 each  shared port responses.
REQ-015 caravel_wb_data_i  input  32  shared port read data.

Function
REQ-016 State register SHALL take values IDLE, GRANT0, GRANT1 and FAULT; a lastGrant register SHALL hold the index of the most recent grant.
REQ-017 In IDLE with exactly one masterN_wb_cyc_i high, the arbiter SHALL enter GRANTN on the next edge.
REQ-018 In IDLE with both cyc high, the arbiter SHALL grant the master not equal to lastGrant (round-robin).
REQ-019 On entering GRANTN, lastGrant SHALL be set to N.
REQ-020 Latency from masterN cyc rising to caravel_wb_cyc_o high SHALL be exactly 1 cycle.
REQ-021 In GRANTN, caravel cyc/stb/we/sel/adr/data_o SHALL equal master N's inputs combinationally.
REQ-022 In GRANTN, masterN ack/stall/error/data_o SHALL equal caravel ack_i/stall_i/error_i/data_i combinationally.
REQ-023 In any state other than IDLE, the non-granted master SHALL see ack_o=0, error_o=0, data_o=0, and stall_o equal to its own cyc_i.
REQ-024 In IDLE, every masterN_wb_stall_o SHALL equal masterN_wb_cyc_i; all other masterN outputs SHALL be 0.
REQ-025 When no grant is held, caravel cyc/stb/we SHALL be 0, sel 4'h0, adr 28'h0, data_o 32'h0.
REQ-026 GRANTN SHALL return to IDLE on the first edge where masterN_wb_cyc_i is low; a release and a new grant SHALL never occur on the same edge.
REQ-027 An 8-bit timeout counter SHALL clear on grant and on any cycle with ack_i or error_i high, and SHALL increment on every other GRANTN cycle, saturating at 8'hFF.
REQ-028 When TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES while in GRANTN, the arbiter SHALL enter FAULT on the next edge.
REQ-029 On the first FAULT cycle, masterN_wb_error_o SHALL pulse high for exactly one cycle; caravel_wb_cyc_o SHALL be 0 throughout FAULT.
REQ-030 FAULT SHALL return to IDLE on the first edge where the faulted master's cyc_i is low.
REQ-031 A caravel ack_i or error_i arriving in IDLE or FAULT SHALL be discarded.

Reset
REQ-032 Asserting wb_rst_i SHALL immediately force state=IDLE, lastGrant=1, counter=0, regardless of the clock.
REQ-033 During and directly after reset, all caravel outputs SHALL be 0 and every masterN output SHALL be 0, except stall_o, which follows REQ-024.
REQ-034 Reset during GRANTN SHALL drop caravel_wb_cyc_o within the same cycle, with no ack forwarded afterwards.

Verification
REQ-035 Only master0 cyc=1, adr=28'h0000010, read; slave acks with 32'hDEADBEEF 2 cycles later -> caravel_wb_cyc_o high 1 cycle after cyc; master0_wb_data_o=32'hDEADBEEF with ack; IDLE after cyc drops.
REQ-036 Both cyc rise together after reset -> master0 granted first and master1_stall_o=1; after master0 releases, master1 granted 1 cycle later; repeat -> master0 granted again.
REQ-037 With TIMEOUT_CYCLES=4, master1 granted and no ack ever -> FAULT entered 5 cycles after grant; master1_error_o is a single-cycle pulse; caravel_wb_cyc_o=0; IDLE after master1 drops cyc.
REQ-038 Reset asserted mid-transfer in GRANT0 -> caravel_wb_cyc_o=0 before the next edge; a late ack_i is not seen at master0_wb_ack_o.
REQ-039 With TIMEOUT_CYCLES=0 and no ack for 300 cycles -> no FAULT, and the counter saturates at 8'hFF.

Source files
------------

// File: rtl/caravel_bus_arbiter.sv
// rtl/caravel_bus_arbiter.sv - two-requester round-robin wishbone arbiter with bus timeout
module caravel_bus_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        master0_wb_cyc_i,
  input  logic        master0_wb_stb_i,
  input  logic        master0_wb_we_i,
  input  logic [3:0]  master0_wb_sel_i,
  input  logic [31:0] master0_wb_data_i,
  input  logic [27:0] master0_wb_adr_i,
  output logic        master0_wb_ack_o,
  output logic        master0_wb_stall_o,
  output logic        master0_wb_error_o,
  output logic [31:0] master0_wb_data_o,

  input  logic        master1_wb_cyc_i,
  input  logic        master1_wb_stb_i,
  input  logic        master1_wb_we_i,
  input  logic [3:0]  master1_wb_sel_i,
  input  logic [31:0] master1_wb_data_i,
  input  logic [27:0] master1_wb_adr_i,
  output logic        master1_wb_ack_o,
  output logic        master1_wb_stall_o,
  output logic        master1_wb_error_o,
  output logic [31:0] master1_wb_data_o,

  output logic        caravel_wb_cyc_o,
  output logic        caravel_wb_stb_o,
  output logic        caravel_wb_we_o,
  output logic [3:0]  caravel_wb_sel_o,
  output logic [31:0] caravel_wb_data_o,
  output logic [27:0] caravel_wb_adr_o,
  input  logic        caravel_wb_ack_i,
  input  logic        caravel_wb_stall_i,
  input  logic        caravel_wb_error_i,
  input  logic [31:0] caravel_wb_data_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  logic [1:0] state;
  logic       last_grant;
  logic [7:0] timeout_cnt;
  logic       fault_master;
  logic       fault_pulse;

  logic grant_cyc;
  logic fault_cyc;
  logic timeout_hit;

  assign grant_cyc   = (state == GRANT1) ? master1_wb_cyc_i : master0_wb_cyc_i;
  assign fault_cyc   = fault_master ? master1_wb_cyc_i : master0_wb_cyc_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 8'd0) && (timeout_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      timeout_cnt  <= 8'd0;
      fault_master <= 1'b0;
      fault_pulse  <= 1'b0;
    end else begin
      fault_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // On contention, the requester that did not win last time goes first.
          if (master0_wb_cyc_i && (!master1_wb_cyc_i || last_grant)) begin
            state       <= GRANT0;
            last_grant  <= 1'b0;
            timeout_cnt <= 8'd0;
          end else if (master1_wb_cyc_i) begin
            state       <= GRANT1;
            last_grant  <= 1'b1;
            timeout_cnt <= 8'd0;
          end
        end
        GRANT0, GRANT1: begin
          if (caravel_wb_ack_i || caravel_wb_error_i)
            timeout_cnt <= 8'd0;
          else if (timeout_cnt != 8'hFF)
            timeout_cnt <= timeout_cnt + 8'd1;
          // Release wins over timeout, and always passes through IDLE before a new grant.
          if (!grant_cyc) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            state        <= FAULT;
            fault_master <= (state == GRANT1);
            fault_pulse  <= 1'b1;
          end
        end
        default: begin
          if (!fault_cyc)
            state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    caravel_wb_cyc_o   = 1'b0;
    caravel_wb_stb_o   = 1'b0;
    caravel_wb_we_o    = 1'b0;
    caravel_wb_sel_o   = 4'h0;
    caravel_wb_data_o  = 32'h0;
    caravel_wb_adr_o   = 28'h0;
    master0_wb_ack_o   = 1'b0;
    master0_wb_stall_o = master0_wb_cyc_i;
    master0_wb_error_o = 1'b0;
    master0_wb_data_o  = 32'h0;
    master1_wb_ack_o   = 1'b0;
    master1_wb_stall_o = master1_wb_cyc_i;
    master1_wb_error_o = 1'b0;
    master1_wb_data_o  = 32'h0;
    case (state)
      GRANT0: begin
        caravel_wb_cyc_o   = master0_wb_cyc_i;
        caravel_wb_stb_o   = master0_wb_stb_i;
        caravel_wb_we_o    = master0_wb_we_i;
        caravel_wb_sel_o   = master0_wb_sel_i;
        caravel_wb_data_o  = master0_wb_data_i;
        caravel_wb_adr_o   = master0_wb_adr_i;
        master0_wb_ack_o   = caravel_wb_ack_i;
        master0_wb_stall_o = caravel_wb_stall_i;
        master0_wb_error_o = caravel_wb_error_i;
        master0_wb_data_o  = caravel_wb_data_i;
      end
      GRANT1: begin
        caravel_wb_cyc_o   = master1_wb_cyc_i;
        caravel_wb_stb_o   = master1_wb_stb_i;
        caravel_wb_we_o    = master1_wb_we_i;
        caravel_wb_sel_o   = master1_wb_sel_i;
        caravel_wb_data_o  = master1_wb_data_i;
        caravel_wb_adr_o   = master1_wb_adr_i;
        master1_wb_ack_o   = caravel_wb_ack_i;
        master1_wb_stall_o = caravel_wb_stall_i;
        master1_wb_error_o = caravel_wb_error_i;
        master1_wb_data_o  = caravel_wb_data_i;
      end
      FAULT: begin
        if (fault_master)
          master1_wb_error_o = fault_pulse;
        else
          master0_wb_error_o = fault_pulse;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_caravel_bus_arbiter.sv
// tb/tb_caravel_bus_arbiter.sv - directed scenario bench for caravel_bus_arbiter
module tb_caravel_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_wdata, m1_wdata;
  logic [27:0] m0_adr, m1_adr;
  logic        s_ack, s_stall, s_err;
  logic [31:0] s_rdata;

  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        c_cyc, c_stb, c_we;
  logic [3:0]  c_sel;
  logic [31:0] c_wdata;
  logic [27:0] c_adr;

  logic        n_m0_ack, n_m0_stall, n_m0_err, n_m1_ack, n_m1_stall, n_m1_err;
  logic [31:0] n_m0_rdata, n_m1_rdata;
  logic        n_cyc, n_stb, n_we;
  logic [3:0]  n_sel;
  logic [31:0] n_wdata;
  logic [27:0] n_adr;

  int total = 0;
  int bad = 0;

  caravel_bus_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .master0_wb_cyc_i(m0_cyc), .master0_wb_stb_i(m0_stb), .master0_wb_we_i(m0_we),
    .master0_wb_sel_i(m0_sel), .master0_wb_data_i(m0_wdata), .master0_wb_adr_i(m0_adr),
    .master0_wb_ack_o(m0_ack), .master0_wb_stall_o(m0_stall), .master0_wb_error_o(m0_err),
    .master0_wb_data_o(m0_rdata),
    .master1_wb_cyc_i(m1_cyc), .master1_wb_stb_i(m1_stb), .master1_wb_we_i(m1_we),
    .master1_wb_sel_i(m1_sel), .master1_wb_data_i(m1_wdata), .master1_wb_adr_i(m1_adr),
    .master1_wb_ack_o(m1_ack), .master1_wb_stall_o(m1_stall), .master1_wb_error_o(m1_err),
    .master1_wb_data_o(m1_rdata),
    .caravel_wb_cyc_o(c_cyc), .caravel_wb_stb_o(c_stb), .caravel_wb_we_o(c_we),
    .caravel_wb_sel_o(c_sel), .caravel_wb_data_o(c_wdata), .caravel_wb_adr_o(c_adr),
    .caravel_wb_ack_i(s_ack), .caravel_wb_stall_i(s_stall), .caravel_wb_error_i(s_err),
    .caravel_wb_data_i(s_rdata)
  );

  caravel_bus_arbiter #(.TIMEOUT_CYCLES(8'd0)) dut_nt (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .master0_wb_cyc_i(m0_cyc), .master0_wb_stb_i(m0_stb), .master0_wb_we_i(m0_we),
    .master0_wb_sel_i(m0_sel), .master0_wb_data_i(m0_wdata), .master0_wb_adr_i(m0_adr),
    .master0_wb_ack_o(n_m0_ack), .master0_wb_stall_o(n_m0_stall), .master0_wb_error_o(n_m0_err),
    .master0_wb_data_o(n_m0_rdata),
    .master1_wb_cyc_i(m1_cyc), .master1_wb_stb_i(m1_stb), .master1_wb_we_i(m1_we),
    .master1_wb_sel_i(m1_sel), .master1_wb_data_i(m1_wdata), .master1_wb_adr_i(m1_adr),
    .master1_wb_ack_o(n_m1_ack), .master1_wb_stall_o(n_m1_stall), .master1_wb_error_o(n_m1_err),
    .master1_wb_data_o(n_m1_rdata),
    .caravel_wb_cyc_o(n_cyc), .caravel_wb_stb_o(n_stb), .caravel_wb_we_o(n_we),
    .caravel_wb_sel_o(n_sel), .caravel_wb_data_o(n_wdata), .caravel_wb_adr_o(n_adr),
    .caravel_wb_ack_i(s_ack), .caravel_wb_stall_i(s_stall), .caravel_wb_error_i(s_err),
    .caravel_wb_data_i(s_rdata)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_wdata = 32'h0; m0_adr = 28'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_wdata = 32'h0; m1_adr = 28'h0;
    s_ack = 0; s_stall = 0; s_err = 0; s_rdata = 32'h0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    m0_cyc = 1; m0_stb = 1; m0_adr = 28'h0000123; s_ack = 1; s_rdata = 32'hFFFFFFFF;
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%0h want=0", c_cyc); end
    total++; if (c_adr !== 28'h0) begin bad++; $display("FAIL rst_adr got=%0h want=0", c_adr); end
    total++; if (m0_stall !== 1'b1) begin bad++; $display("FAIL rst_m0_stall got=%0h want=1", m0_stall); end
    total++; if (m1_stall !== 1'b0) begin bad++; $display("FAIL rst_m1_stall got=%0h want=0", m1_stall); end
    total++; if (m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL rst_m0_resp got=%0h/%0h want=0/0", m0_ack, m0_rdata); end
    step();
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL rst_held_cyc got=%0h want=0", c_cyc); end
    rst = 1'b0;
    #1;
    total++; if (c_cyc !== 1'b0 || m0_ack !== 1'b0) begin bad++; $display("FAIL rst_after got=%0h/%0h want=0/0", c_cyc, m0_ack); end
    clear_inputs();
  endtask

  task automatic test_single_read;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 28'h0000010;
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL rd_pre_cyc got=%0h want=0", c_cyc); end
    total++; if (m0_stall !== 1'b1) begin bad++; $display("FAIL rd_pre_stall got=%0h want=1", m0_stall); end
    step();
    #2;
    total++; if (c_cyc !== 1'b1 || c_stb !== 1'b1 || c_we !== 1'b0) begin bad++; $display("FAIL rd_grant got=%0h%0h%0h want=110", c_cyc, c_stb, c_we); end
    total++; if (c_adr !== 28'h0000010 || c_sel !== 4'hF) begin bad++; $display("FAIL rd_adr got=%0h/%0h want=10/f", c_adr, c_sel); end
    total++; if (m0_stall !== 1'b0) begin bad++; $display("FAIL rd_stall got=%0h want=0", m0_stall); end
    step();
    step();
    s_ack = 1; s_rdata = 32'hDEADBEEF;
    #2;
    total++; if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_ack got=%0h/%0h want=1/deadbeef", m0_ack, m0_rdata); end
    total++; if (m1_ack !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rd_m1_quiet got=%0h/%0h want=0/0", m1_ack, m1_rdata); end
    step();
    s_ack = 0; s_rdata = 32'h0; m0_cyc = 0; m0_stb = 0;
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL rd_release_cyc got=%0h want=0", c_cyc); end
    step();
    s_ack = 1; s_rdata = 32'h12345678;
    #2;
    total++; if (m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL rd_idle_ack got=%0h/%0h want=0/0", m0_ack, m0_rdata); end
    total++; if (c_adr !== 28'h0 || c_sel !== 4'h0) begin bad++; $display("FAIL rd_idle_bus got=%0h/%0h want=0/0", c_adr, c_sel); end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 28'h0000100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 28'h0000200;
    #2;
    total++; if (m1_stall !== 1'b1 || m0_stall !== 1'b1) begin bad++; $display("FAIL rr_idle_stall got=%0h%0h want=11", m0_stall, m1_stall); end
    step();
    #2;
    total++; if (c_adr !== 28'h0000100) begin bad++; $display("FAIL rr_first got=%0h want=100", c_adr); end
    total++; if (m1_stall !== 1'b1 || m0_stall !== 1'b0) begin bad++; $display("FAIL rr_first_stall got=%0h%0h want=01", m0_stall, m1_stall); end
    s_ack = 1; s_rdata = 32'h11112222;
    #1;
    total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rr_ack_route got=%0h%0h/%0h want=10/0", m0_ack, m1_ack, m1_rdata); end
    step();
    s_ack = 0; s_rdata = 32'h0; m0_cyc = 0; m0_stb = 0;
    #2;
    total++; if (c_cyc !== 1'b0 || m1_stall !== 1'b1) begin bad++; $display("FAIL rr_release got=%0h/%0h want=0/1", c_cyc, m1_stall); end
    step();
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL rr_no_same_edge got=%0h want=0", c_cyc); end
    step();
    #2;
    total++; if (c_cyc !== 1'b1 || c_adr !== 28'h0000200 || m1_stall !== 1'b0) begin bad++; $display("FAIL rr_second got=%0h/%0h/%0h want=1/200/0", c_cyc, c_adr, m1_stall); end
    m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 1; s_ack = 1;
    #2;
    total++; if (m0_ack !== 1'b0 || m0_stall !== 1'b1) begin bad++; $display("FAIL rr_m0_wait got=%0h/%0h want=0/1", m0_ack, m0_stall); end
    step();
    s_ack = 0; m1_cyc = 1; m1_stb = 1;
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL rr_idle2 got=%0h want=0", c_cyc); end
    step();
    #2;
    total++; if (c_adr !== 28'h0000100 || m1_stall !== 1'b1) begin bad++; $display("FAIL rr_third got=%0h/%0h want=100/1", c_adr, m1_stall); end
    clear_inputs();
  endtask

  task automatic test_timeout;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_adr = 28'h0ABCDEF; m1_wdata = 32'hCAFEF00D;
    step();
    #2;
    total++; if (c_cyc !== 1'b1 || c_we !== 1'b1 || c_sel !== 4'h3 || c_wdata !== 32'hCAFEF00D || c_adr !== 28'h0ABCDEF)
      begin bad++; $display("FAIL to_grant got=%0h/%0h/%0h/%0h/%0h want=1/1/3/cafef00d/abcdef", c_cyc, c_we, c_sel, c_wdata, c_adr); end
    for (int k = 1; k <= 4; k++) begin
      step();
      #2;
      total++; if (c_cyc !== 1'b1 || m1_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%0h/%0h want=1/0", k, c_cyc, m1_err); end
    end
    step();
    #2;
    total++; if (m1_err !== 1'b1 || c_cyc !== 1'b0 || m1_stall !== 1'b1) begin bad++; $display("FAIL to_fault got=%0h/%0h/%0h want=1/0/1", m1_err, c_cyc, m1_stall); end
    total++; if (m0_err !== 1'b0) begin bad++; $display("FAIL to_m0_err got=%0h want=0", m0_err); end
    s_ack = 1;
    step();
    #2;
    total++; if (m1_err !== 1'b0 || c_cyc !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL to_fault2 got=%0h/%0h/%0h want=0/0/0", m1_err, c_cyc, m1_ack); end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
    m1_cyc = 1; m1_stb = 1;
    #2;
    total++; if (c_cyc !== 1'b0) begin bad++; $display("FAIL to_idle got=%0h want=0", c_cyc); end
    step();
    #2;
    total++; if (c_cyc !== 1'b1) begin bad++; $display("FAIL to_regrant got=%0h want=1", c_cyc); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_transfer;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 28'h0000044;
    step();
    #2;
    total++; if (c_cyc !== 1'b1) begin bad++; $display("FAIL mid_grant got=%0h want=1", c_cyc); end
    rst = 1'b1;
    #1;
    total++; if (c_cyc !== 1'b0 || c_adr !== 28'h0) begin bad++; $display("FAIL mid_drop got=%0h/%0h want=0/0", c_cyc, c_adr); end
    s_ack = 1; s_rdata = 32'h55AA55AA;
    #1;
    total++; if (m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin bad++; $display("FAIL mid_late_ack got=%0h/%0h want=0/0", m0_ack, m0_rdata); end
    step();
    rst = 1'b0;
    #1;
    total++; if (m0_ack !== 1'b0 || c_cyc !== 1'b0) begin bad++; $display("FAIL mid_after got=%0h/%0h want=0/0", m0_ack, c_cyc); end
    clear_inputs();
    step();
  endtask

  task automatic test_no_timeout;
    int lost;
    lost = 0;
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    repeat (300) begin
      step();
      #2;
      if (n_cyc !== 1'b1 || n_m0_err !== 1'b0) lost++;
    end
    total++; if (lost != 0) begin bad++; $display("FAIL nt_held got=%0d want=0", lost); end
    total++; if (dut_nt.timeout_cnt !== 8'hFF) begin bad++; $display("FAIL nt_sat got=%0h want=ff", dut_nt.timeout_cnt); end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_reset_mid_transfer();
    test_no_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
